// File: rtl/irq_controller_pkg.sv
// Shared register map and bus write helper for the interrupt controller.
package irq_controller_pkg;

  // Word offsets, decoded from addr[7:2]
  localparam logic [5:0] REG_PENDING  = 6'h00;
  localparam logic [5:0] REG_ENABLE   = 6'h01;
  localparam logic [5:0] REG_MODE     = 6'h02;
  localparam logic [5:0] REG_POLARITY = 6'h03;
  localparam logic [5:0] REG_RAW      = 6'h04;
  localparam logic [5:0] REG_SWSET    = 6'h05;

  // Merge write data into a register value, one byte lane per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser with polarity-aware edge/level detection.
module irq_sync_edge
  import irq_controller_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  input  logic polarity_i,
  input  logic mode_i,      // 1 = edge, 0 = level
  output logic raw_o,
  output logic set_req_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  hist_q, hist_d;
  logic                  s, p;

  // Shift the pin through the synchroniser; history keeps the previous raw level.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], pin_i};
    hist_d = sync_q[SyncStages-1];
  end

  // Synchroniser and history state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign raw_o = sync_q[SyncStages-1];

  // Polarity is applied to current and previous level alike, so flipping
  // polarity on a static pin can never look like an edge.
  assign s         = raw_o ^ polarity_i;
  assign p         = hist_q ^ polarity_i;
  assign set_req_o = mode_i ? (s & ~p) : s;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller feeding the CPU irq vector.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned IRQ_BASE    = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid,
  output logic               ready,
  input  logic [3:0]         wstrb,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [NUM_SRC-1:0] src,
  output logic [31:0]        irq
);

  logic               ready_q, ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        irq_q, irq_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pol_q, pol_d;
  logic [NUM_SRC-1:0] raw, set_req, swset;

  logic [5:0]  reg_idx;
  logic        wr_en;
  logic [31:0] wmask, en_wr, mode_wr, pol_wr;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_sync_edge #(
      .SyncStages (SYNC_STAGES)
    ) u_sync_edge (
      .clk_i      (clk),
      .rst_ni     (resetn),
      .pin_i      (src[i]),
      .polarity_i (pol_q[i]),
      .mode_i     (mode_q[i]),
      .raw_o      (raw[i]),
      .set_req_o  (set_req[i])
    );
  end

  assign reg_idx = addr[7:2];
  // Writes commit on the ready cycle, while the master still holds the request.
  assign wr_en   = valid && ready_q && (wstrb != 4'h0);

  // Byte-lane merged write values.
  always_comb begin
    wmask   = apply_wstrb(32'h0, wdata, wstrb);
    en_wr   = apply_wstrb(32'(enable_q), wdata, wstrb);
    mode_wr = apply_wstrb(32'(mode_q), wdata, wstrb);
    pol_wr  = apply_wstrb(32'(pol_q), wdata, wstrb);
  end

  // Bus handshake, read mux, register updates and irq vector.
  always_comb begin
    ready_d   = valid && !ready_q;
    rdata_d   = 32'h0;
    pending_d = pending_q;
    enable_d  = enable_q;
    mode_d    = mode_q;
    pol_d     = pol_q;
    swset     = '0;

    if (ready_d && (wstrb == 4'h0)) begin
      case (reg_idx)
        REG_PENDING:  rdata_d = 32'(pending_q);
        REG_ENABLE:   rdata_d = 32'(enable_q);
        REG_MODE:     rdata_d = 32'(mode_q);
        REG_POLARITY: rdata_d = 32'(pol_q);
        REG_RAW:      rdata_d = 32'(raw);
        default:      rdata_d = 32'h0;
      endcase
    end

    if (wr_en) begin
      case (reg_idx)
        REG_PENDING:  pending_d = pending_q & ~wmask[NUM_SRC-1:0];
        REG_ENABLE:   enable_d  = en_wr[NUM_SRC-1:0];
        REG_MODE:     mode_d    = mode_wr[NUM_SRC-1:0];
        REG_POLARITY: pol_d     = pol_wr[NUM_SRC-1:0];
        REG_SWSET:    swset     = wmask[NUM_SRC-1:0];
        default:      ;
      endcase
    end

    // Set beats clear: applied after the W1C.
    pending_d = pending_d | set_req | swset;

    irq_d = 32'h0;
    irq_d[IRQ_BASE +: NUM_SRC] = pending_q & enable_q;
  end

  // Register state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q   <= 1'b0;
      rdata_q   <= 32'h0;
      irq_q     <= 32'h0;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      pol_q     <= '0;
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pol_q     <= pol_d;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign irq   = irq_q;

  logic unused_bits;
  assign unused_bits = ^{addr[31:8], addr[1:0], wmask[31:NUM_SRC], en_wr[31:NUM_SRC],
                         mode_wr[31:NUM_SRC], pol_wr[31:NUM_SRC]};

endmodule
